// File: rtl/reg_file_sb_if.sv
// Register file + scoreboard bus: read ports, write port, allocation port and debug tap.
// The issue/commit side is the master; the register file is the slave.
interface reg_file_sb_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32
);
   localparam int unsigned AW = $clog2(NREG);

   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic [XLEN-1:0] rs1_dout;
   logic [XLEN-1:0] rs2_dout;
   logic            rs1_busy;
   logic            rs2_busy;
   logic [AW-1:0]   rd;
   logic [XLEN-1:0] rd_din;
   logic            write_enable;
   logic            alloc_valid;
   logic [AW-1:0]   alloc_rd;
   logic [AW-1:0]   dbg_sel;
   logic [XLEN-1:0] dbg_dout;
   logic [AW:0]     busy_cnt;

   modport master (
      output rs1, rs2, rd, rd_din, write_enable, alloc_valid, alloc_rd, dbg_sel,
      input  rs1_dout, rs2_dout, rs1_busy, rs2_busy, dbg_dout, busy_cnt
   );

   modport slave (
      input  rs1, rs2, rd, rd_din, write_enable, alloc_valid, alloc_rd, dbg_sel,
      output rs1_dout, rs2_dout, rs1_busy, rs2_busy, dbg_dout, busy_cnt
   );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file with a pending-write scoreboard and a registered debug tap.
// x0 reads as zero and is never written or marked busy.
// Optional feature: define RF_BYPASS_EN to forward a same-cycle write to the read ports.
module reg_file_sb #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NREG    = 32,
   parameter int unsigned SP_IDX  = 2,
   parameter logic [31:0] SP_INIT = 32'h2ffc
) (
   input logic           clk,
   input logic           reset,
   reg_file_sb_if.slave  bus
);
   localparam int unsigned AW = $clog2(NREG);
   localparam logic [XLEN-1:0] SpInitX = XLEN'(SP_INIT);

   logic [XLEN-1:0] r_rf [NREG];
   logic [NREG-1:0] r_busy;
   logic [AW:0]     r_busy_cnt;
   logic [XLEN-1:0] r_dbg_dout;

   logic            w_wr_hit;
   logic            w_alloc_hit;
   logic [NREG-1:0] w_busy_nxt;
   logic [AW:0]     w_busy_cnt_nxt;

   assign w_wr_hit    = bus.write_enable && (bus.rd != '0);
   assign w_alloc_hit = bus.alloc_valid && (bus.alloc_rd != '0);

   // Scoreboard next state: commit clears, then a new claim wins on the same register.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wr_hit) begin
         w_busy_nxt[bus.rd] = 1'b0;
      end
      if (w_alloc_hit) begin
         w_busy_nxt[bus.alloc_rd] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   // Population count of the post-edge scoreboard, registered alongside the busy bits.
   always_comb begin
      w_busy_cnt_nxt = '0;
      for (int i = 0; i < NREG; i++) begin
         w_busy_cnt_nxt = w_busy_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
      end
   end

   // Register array, scoreboard, count and debug capture; reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            r_rf[i] <= '0;
         end
         r_rf[AW'(SP_IDX)] <= SpInitX;
         r_busy            <= '0;
         r_busy_cnt        <= '0;
         r_dbg_dout        <= '0;
      end else begin
         if (w_wr_hit) begin
            r_rf[bus.rd] <= bus.rd_din;
         end
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= w_busy_cnt_nxt;
         // Reads the pre-write array, so a same-cycle write to dbg_sel shows a cycle later.
         r_dbg_dout <= r_rf[bus.dbg_sel];
      end
   end

   // Combinational read ports with optional write-through forwarding.
   always_comb begin
      bus.rs1_dout = (bus.rs1 == '0) ? '0 : r_rf[bus.rs1];
      bus.rs2_dout = (bus.rs2 == '0) ? '0 : r_rf[bus.rs2];
      bus.rs1_busy = r_busy[bus.rs1];
      bus.rs2_busy = r_busy[bus.rs2];
`ifdef RF_BYPASS_EN
      if (w_wr_hit && (bus.rs1 == bus.rd)) begin
         bus.rs1_dout = bus.rd_din;
         bus.rs1_busy = bus.alloc_valid && (bus.alloc_rd == bus.rd);
      end
      if (w_wr_hit && (bus.rs2 == bus.rd)) begin
         bus.rs2_dout = bus.rd_din;
         bus.rs2_busy = bus.alloc_valid && (bus.alloc_rd == bus.rd);
      end
`endif
   end

   assign bus.busy_cnt = r_busy_cnt;
   assign bus.dbg_dout = r_dbg_dout;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb; expectations follow RF_BYPASS_EN when it is defined.
module tb_reg_file_sb;
   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   reg_file_sb_if #(.XLEN(32), .NREG(32)) bus ();

   reg_file_sb #(
      .XLEN   (32),
      .NREG   (32),
      .SP_IDX (2),
      .SP_INIT(32'h2ffc)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle before the caller drives or samples.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.write_enable = 1'b0;
      bus.alloc_valid  = 1'b0;
      bus.rd           = '0;
      bus.rd_din       = '0;
      bus.alloc_rd     = '0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      bus.rs1 = '0;
      bus.rs2 = '0;
      bus.dbg_sel = '0;
      idle();
      #2;
      step();
      step();
      reset = 1'b0;

      // Reset state
      bus.rs1 = 5'd2;
      bus.rs2 = 5'd5;
      #1;
      check("rst_x2", bus.rs1_dout, 32'h2ffc);
      check("rst_x5", bus.rs2_dout, 32'h0);
      check("rst_cnt", 32'(bus.busy_cnt), 32'd0);
      check("rst_dbg", bus.dbg_dout, 32'h0);
      check("rst_busy", 32'(bus.rs1_busy), 32'd0);
      bus.dbg_sel = 5'd2;
      step();
      check("dbg_sp", bus.dbg_dout, 32'h2ffc);

      // x0 guard: write and alloc to x0 are both discarded
      bus.write_enable = 1'b1;
      bus.rd           = 5'd0;
      bus.rd_din       = 32'hdead;
      bus.alloc_valid  = 1'b1;
      bus.alloc_rd     = 5'd0;
      bus.rs1          = 5'd0;
      bus.dbg_sel      = 5'd0;
      #1;
      check("x0_rd_same", bus.rs1_dout, 32'h0);
      step();
      idle();
      #1;
      check("x0_rd", bus.rs1_dout, 32'h0);
      check("x0_cnt", 32'(bus.busy_cnt), 32'd0);
      check("x0_busy", 32'(bus.rs1_busy), 32'd0);
      step();
      check("x0_dbg", bus.dbg_dout, 32'h0);

      // Scoreboard: alloc x5, redundant alloc, then commit
      bus.alloc_valid = 1'b1;
      bus.alloc_rd    = 5'd5;
      step();
      idle();
      bus.rs1 = 5'd5;
      #1;
      check("sb_busy", 32'(bus.rs1_busy), 32'd1);
      check("sb_cnt", 32'(bus.busy_cnt), 32'd1);
      bus.alloc_valid = 1'b1;
      bus.alloc_rd    = 5'd5;
      step();
      idle();
      #1;
      check("sb_redund_cnt", 32'(bus.busy_cnt), 32'd1);
      check("sb_redund_busy", 32'(bus.rs1_busy), 32'd1);
      bus.write_enable = 1'b1;
      bus.rd           = 5'd5;
      bus.rd_din       = 32'h1234;
      #1;
`ifdef RF_BYPASS_EN
      check("sb_fwd_dout", bus.rs1_dout, 32'h1234);
      check("sb_fwd_busy", 32'(bus.rs1_busy), 32'd0);
`else
      check("sb_old_dout", bus.rs1_dout, 32'h0);
      check("sb_old_busy", 32'(bus.rs1_busy), 32'd1);
`endif
      step();
      idle();
      #1;
      check("sb_wr_busy", 32'(bus.rs1_busy), 32'd0);
      check("sb_wr_cnt", 32'(bus.busy_cnt), 32'd0);
      check("sb_wr_dout", bus.rs1_dout, 32'h1234);

      // Simultaneous alloc and write on x7: claim wins
      bus.rs2          = 5'd7;
      bus.alloc_valid  = 1'b1;
      bus.alloc_rd     = 5'd7;
      bus.write_enable = 1'b1;
      bus.rd           = 5'd7;
      bus.rd_din       = 32'h55;
      #1;
`ifdef RF_BYPASS_EN
      check("sim_fwd_dout", bus.rs2_dout, 32'h55);
      check("sim_fwd_busy", 32'(bus.rs2_busy), 32'd1);
`else
      check("sim_old_dout", bus.rs2_dout, 32'h0);
      check("sim_old_busy", 32'(bus.rs2_busy), 32'd0);
`endif
      step();
      idle();
      #1;
      check("sim_dout", bus.rs2_dout, 32'h55);
      check("sim_busy", 32'(bus.rs2_busy), 32'd1);
      check("sim_cnt", 32'(bus.busy_cnt), 32'd1);

      // Bypass on rs2 with a write to non-busy x9
      bus.rs2          = 5'd9;
      bus.write_enable = 1'b1;
      bus.rd           = 5'd9;
      bus.rd_din       = 32'hcafe;
      #1;
`ifdef RF_BYPASS_EN
      check("byp_dout", bus.rs2_dout, 32'hcafe);
`else
      check("byp_old", bus.rs2_dout, 32'h0);
`endif
      check("byp_busy", 32'(bus.rs2_busy), 32'd0);
      step();
      idle();
      #1;
      check("byp_after", bus.rs2_dout, 32'hcafe);
      check("byp_nb_busy", 32'(bus.rs2_busy), 32'd0);
      check("byp_cnt", 32'(bus.busy_cnt), 32'd1);

      // Debug capture shows pre-write value on a same-cycle write
      bus.dbg_sel      = 5'd9;
      bus.write_enable = 1'b1;
      bus.rd           = 5'd9;
      bus.rd_din       = 32'hbeef;
      step();
      idle();
      #1;
      check("dbg_prewr", bus.dbg_dout, 32'hcafe);
      step();
      check("dbg_postwr", bus.dbg_dout, 32'hbeef);

      // Reset mid-operation: x3, x4 busy, reset alongside write to x3
      bus.alloc_valid = 1'b1;
      bus.alloc_rd    = 5'd3;
      step();
      bus.alloc_rd    = 5'd4;
      step();
      idle();
      #1;
      check("mid_cnt3", 32'(bus.busy_cnt), 32'd3);
      reset            = 1'b1;
      bus.write_enable = 1'b1;
      bus.rd           = 5'd3;
      bus.rd_din       = 32'h1111;
      bus.alloc_valid  = 1'b1;
      bus.alloc_rd     = 5'd10;
      bus.dbg_sel      = 5'd3;
      step();
      reset = 1'b0;
      idle();
      bus.rs1 = 5'd3;
      bus.rs2 = 5'd2;
      #1;
      check("mid_cnt", 32'(bus.busy_cnt), 32'd0);
      check("mid_x3", bus.rs1_dout, 32'h0);
      check("mid_busy3", 32'(bus.rs1_busy), 32'd0);
      check("mid_sp", bus.rs2_dout, 32'h2ffc);
      check("mid_dbg_rst", bus.dbg_dout, 32'h0);
      bus.rs2 = 5'd9;
      #1;
      check("mid_x9", bus.rs2_dout, 32'h0);
      step();
      check("mid_dbg3", bus.dbg_dout, 32'h0);
      bus.dbg_sel = 5'd2;
      step();
      check("mid_dbg_sp", bus.dbg_dout, 32'h2ffc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count, power of two, 2..64; AW = log2(NREG).
REQ-003 SHALL have parameter SP_IDX, default 2, index of the stack pointer register.
REQ-004 SHALL have parameter SP_INIT, default 32'h2ffc, stack-pointer reset value, truncated or zero-extended to XLEN.
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-006 SHALL have the following ports:
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous active-high reset
- rs1, rs2  in  AW  read addresses
- rs1_dout, rs2_dout  out  XLEN  read data
- rs1_busy, rs2_busy  out  1  pending-write flag of rs1/rs2
- rd  in  AW  write address
- rd_din  in  XLEN  write data
- write_enable  in  1  commit write of rd_din to rd
- alloc_valid  in  1  issue stage claims a register
- alloc_rd  in  AW  register being claimed
- dbg_sel  in  AW  debug register select
- dbg_dout  out  XLEN  registered copy of the selected register
- busy_cnt  out  AW+1  number of registers with a pending write

Function
REQ-007 SHALL read rs1_dout and rs2_dout combinationally; address 0 SHALL always return 0.
REQ-008 SHALL perform a write to rf[rd] at the clk edge when write_enable=1 and rd!=0; a write to x0 SHALL be discarded.
REQ-009 SHALL hold a scoreboard of NREG busy bits; bit 0 SHALL be constant 0.
REQ-010 SHALL set busy[alloc_rd] at the edge when alloc_valid=1 and alloc_rd!=0.
REQ-011 SHALL clear busy[rd] at the edge when write_enable=1 and rd!=0.
REQ-012 SHALL leave busy[r] at 1 when alloc and write hit the same r in the same cycle, because the new claim wins.
REQ-013 SHALL drive rs1_busy and rs2_busy combinationally from the busy bits, with the bypass adjustments in REQ-020.
REQ-014 SHALL update busy_cnt each cycle as the registered population count of the busy bits after that edge's update; it SHALL be consistent with busy on the same cycle.
REQ-015 SHALL load dbg_dout <= rf[dbg_sel] every edge, with one-cycle latency; it SHALL show the pre-write value when dbg_sel==rd on a write cycle.
REQ-016 SHALL accept a redundant alloc of an already-busy register, which keeps the bit at 1 and leaves busy_cnt unchanged.
REQ-017 SHALL accept a write to a non-busy register, which updates rf and keeps busy at 0.

Reset
REQ-018 SHALL, when reset=1 at an edge, set all rf to 0 except rf[SP_IDX]=SP_INIT, all busy=0, busy_cnt=0, dbg_dout=0.
REQ-019 SHALL give reset priority over a same-cycle write, alloc or debug capture; a pending write lost mid-operation is not recovered.

Configuration
REQ-020 SHALL use macro RF_BYPASS_EN to compile write-through forwarding in or out:
- Defined: when write_enable=1, rd!=0 and rsN==rd, rsN_dout SHALL equal rd_din in the same cycle, and rsN_busy SHALL be 0 unless alloc_valid=1 with alloc_rd==rd.
- Undefined: rsN_dout SHALL show the old rf value until the next edge, and rsN_busy SHALL follow the stored bit.

Verification
REQ-021 SHALL cover reset: pulse reset, then read x2 -> 32'h2ffc, and x5 -> 0, busy_cnt=0.
REQ-022 SHALL cover the x0 guard: write_enable=1, rd=0, rd_din=32'hdead; then read rs1=0 -> 0, and alloc_rd=0 -> busy_cnt stays 0.
REQ-023 SHALL cover the scoreboard: alloc x5, then next cycle rs1=5 -> rs1_busy=1, busy_cnt=1; write x5=32'h1234 -> rs1_busy=0, busy_cnt=0, rs1_dout=32'h1234.
REQ-024 SHALL cover simultaneous events: alloc x7 and write x7=32'h55 in one cycle -> rf[7]=32'h55, busy[7]=1, busy_cnt=1.
REQ-025 SHALL cover bypass: write x9=32'hcafe while rs2=9 -> with RF_BYPASS_EN, rs2_dout=32'hcafe same cycle; without it, old value, then 32'hcafe next cycle.
REQ-026 SHALL cover reset mid-operation: busy set on x3 and x4, reset asserted alongside write_enable on x3 -> busy_cnt=0, rf[3]=0, dbg_sel=3 -> dbg_dout=0 next cycle.
